// File: rtl/difftest_commit_monitor.sv
// Difftest co-simulation monitor: keeps a shadow GPR image built from committed
// writes, checks it against the live register file, and counts cycles/commits/traps.
module difftest_commit_monitor #(
   parameter logic [7:0] CORE_ID = 8'd0
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic [7:0]   coreid,
   input  logic         c1_valid,
   input  logic         c2_valid,
   input  logic [31:0]  c1_pc,
   input  logic [31:0]  c2_pc,
   input  logic [31:0]  c1_instr,
   input  logic [31:0]  c2_instr,
   input  logic         c1_skip,
   input  logic         c2_skip,
   input  logic         c1_is_CNTinst,
   input  logic         c2_is_CNTinst,
   input  logic         c1_is_TLBFILL,
   input  logic         c2_is_TLBFILL,
   input  logic [4:0]   c1_TLBFILL_index,
   input  logic [4:0]   c2_TLBFILL_index,
   input  logic [63:0]  c1_timer_64_value,
   input  logic [63:0]  c2_timer_64_value,
   input  logic [7:0]   c1_index,
   input  logic [7:0]   c2_index,
   input  logic         c1_wen,
   input  logic         c2_wen,
   input  logic [4:0]   c1_wdest,
   input  logic [4:0]   c2_wdest,
   input  logic [31:0]  c1_wdata,
   input  logic [31:0]  c2_wdata,
   input  logic [1023:0] gpr,
   input  logic         trap_valid,
   input  logic [7:0]   trap_code,
   input  logic [31:0]  trap_pc,
   input  logic [63:0]  trap_cycleCnt,
   input  logic [63:0]  trap_instrCnt,
   output logic [63:0]  cycle_cnt,
   output logic [63:0]  instr_cnt,
   output logic         mismatch,
   output logic [4:0]   mismatch_idx,
   output logic [31:0]  mismatch_pc,
   output logic [31:0]  mismatch_expected,
   output logic [31:0]  mismatch_actual,
   output logic         halted,
   output logic         trap_good,
   output logic [7:0]   trap_code_o,
   output logic [31:0]  trap_pc_o,
   output logic         cnt_mismatch
);

   logic [31:0] gpr_a     [32];
   logic [31:0] shadow_q  [32];
   logic [31:0] shadow_d  [32];

   logic [63:0] cycle_cnt_q, cycle_cnt_d;
   logic [63:0] instr_cnt_q, instr_cnt_d;
   logic        mismatch_q, mismatch_d;
   logic [4:0]  mismatch_idx_q, mismatch_idx_d;
   logic [31:0] mismatch_pc_q, mismatch_pc_d;
   logic [31:0] mismatch_exp_q, mismatch_exp_d;
   logic [31:0] mismatch_act_q, mismatch_act_d;
   logic        halted_q, halted_d;
   logic        trap_good_q, trap_good_d;
   logic [7:0]  trap_code_q, trap_code_d;
   logic [31:0] trap_pc_q, trap_pc_d;
   logic        cnt_mismatch_q, cnt_mismatch_d;

   logic        active;
   logic        commit_cycle;
   logic [1:0]  n_commit;
   logic [63:0] instr_cnt_next;
   logic        diff_found;
   logic [4:0]  diff_idx;

   logic unused_inputs;
   assign unused_inputs = ^{c1_instr, c2_instr, c1_is_TLBFILL, c2_is_TLBFILL,
                            c1_TLBFILL_index, c2_TLBFILL_index, c1_timer_64_value,
                            c2_timer_64_value, c1_index, c2_index, trap_cycleCnt};

   always_comb begin
      for (int i = 0; i < 32; i++) gpr_a[i] = gpr[i*32 +: 32];
   end

   assign active         = (coreid == CORE_ID) && !halted_q;
   assign commit_cycle   = active && (c1_valid || c2_valid);
   assign n_commit       = {1'b0, c1_valid} + {1'b0, c2_valid};
   assign instr_cnt_next = instr_cnt_q + {62'd0, n_commit};

   // Slot 1 is older, so slot 2 is applied last and wins on a shared destination.
   always_comb begin
      shadow_d = shadow_q;
      if (active) begin
         if (c1_valid && c1_wen && (c1_wdest != 5'd0))
            shadow_d[c1_wdest] = (c1_skip || c1_is_CNTinst) ? gpr_a[c1_wdest] : c1_wdata;
         if (c2_valid && c2_wen && (c2_wdest != 5'd0))
            shadow_d[c2_wdest] = (c2_skip || c2_is_CNTinst) ? gpr_a[c2_wdest] : c2_wdata;
      end
      shadow_d[0] = 32'd0;
   end

   // Descending scan so the lowest differing register is the one left standing.
   always_comb begin
      diff_found = 1'b0;
      diff_idx   = 5'd0;
      for (int i = 31; i >= 0; i--) begin
         if (shadow_d[i] != gpr_a[i]) begin
            diff_found = 1'b1;
            diff_idx   = i[4:0];
         end
      end
   end

   always_comb begin
      cycle_cnt_d    = halted_q ? cycle_cnt_q : cycle_cnt_q + 64'd1;
      instr_cnt_d    = active ? instr_cnt_next : instr_cnt_q;
      mismatch_d     = mismatch_q;
      mismatch_idx_d = mismatch_idx_q;
      mismatch_pc_d  = mismatch_pc_q;
      mismatch_exp_d = mismatch_exp_q;
      mismatch_act_d = mismatch_act_q;
      halted_d       = halted_q;
      trap_good_d    = trap_good_q;
      trap_code_d    = trap_code_q;
      trap_pc_d      = trap_pc_q;
      cnt_mismatch_d = cnt_mismatch_q;
      if (commit_cycle && diff_found && !mismatch_q) begin
         mismatch_d     = 1'b1;
         mismatch_idx_d = diff_idx;
         mismatch_pc_d  = c2_valid ? c2_pc : c1_pc;
         mismatch_exp_d = shadow_d[diff_idx];
         mismatch_act_d = gpr_a[diff_idx];
      end
      if (active && trap_valid) begin
         halted_d       = 1'b1;
         trap_code_d    = trap_code;
         trap_pc_d      = trap_pc;
         trap_good_d    = (trap_code == 8'd0) && !mismatch_d;
         cnt_mismatch_d = (trap_instrCnt != instr_cnt_next);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) shadow_q[i] <= 32'd0;
         cycle_cnt_q    <= 64'd0;
         instr_cnt_q    <= 64'd0;
         mismatch_q     <= 1'b0;
         mismatch_idx_q <= 5'd0;
         mismatch_pc_q  <= 32'd0;
         mismatch_exp_q <= 32'd0;
         mismatch_act_q <= 32'd0;
         halted_q       <= 1'b0;
         trap_good_q    <= 1'b0;
         trap_code_q    <= 8'd0;
         trap_pc_q      <= 32'd0;
         cnt_mismatch_q <= 1'b0;
      end else begin
         shadow_q       <= shadow_d;
         cycle_cnt_q    <= cycle_cnt_d;
         instr_cnt_q    <= instr_cnt_d;
         mismatch_q     <= mismatch_d;
         mismatch_idx_q <= mismatch_idx_d;
         mismatch_pc_q  <= mismatch_pc_d;
         mismatch_exp_q <= mismatch_exp_d;
         mismatch_act_q <= mismatch_act_d;
         halted_q       <= halted_d;
         trap_good_q    <= trap_good_d;
         trap_code_q    <= trap_code_d;
         trap_pc_q      <= trap_pc_d;
         cnt_mismatch_q <= cnt_mismatch_d;
      end
   end

   assign cycle_cnt         = cycle_cnt_q;
   assign instr_cnt         = instr_cnt_q;
   assign mismatch          = mismatch_q;
   assign mismatch_idx      = mismatch_idx_q;
   assign mismatch_pc       = mismatch_pc_q;
   assign mismatch_expected = mismatch_exp_q;
   assign mismatch_actual   = mismatch_act_q;
   assign halted            = halted_q;
   assign trap_good         = trap_good_q;
   assign trap_code_o       = trap_code_q;
   assign trap_pc_o         = trap_pc_q;
   assign cnt_mismatch      = cnt_mismatch_q;

endmodule

// File: tb/tb_difftest_commit_monitor.sv
// Directed bench for difftest_commit_monitor with hand-computed expectations.
module tb_difftest_commit_monitor;

   logic         clock = 1'b0;
   logic         reset_n;
   logic [7:0]   coreid;
   logic         c1_valid, c2_valid;
   logic [31:0]  c1_pc, c2_pc, c1_instr, c2_instr;
   logic         c1_skip, c2_skip, c1_is_CNTinst, c2_is_CNTinst;
   logic         c1_is_TLBFILL, c2_is_TLBFILL;
   logic [4:0]   c1_TLBFILL_index, c2_TLBFILL_index;
   logic [63:0]  c1_timer_64_value, c2_timer_64_value;
   logic [7:0]   c1_index, c2_index;
   logic         c1_wen, c2_wen;
   logic [4:0]   c1_wdest, c2_wdest;
   logic [31:0]  c1_wdata, c2_wdata;
   logic [1023:0] gpr;
   logic         trap_valid;
   logic [7:0]   trap_code;
   logic [31:0]  trap_pc;
   logic [63:0]  trap_cycleCnt, trap_instrCnt;
   logic [63:0]  cycle_cnt, instr_cnt;
   logic         mismatch;
   logic [4:0]   mismatch_idx;
   logic [31:0]  mismatch_pc, mismatch_expected, mismatch_actual;
   logic         halted, trap_good;
   logic [7:0]   trap_code_o;
   logic [31:0]  trap_pc_o;
   logic         cnt_mismatch;

   int checks = 0;
   int failures = 0;
   logic [63:0] exp_cyc = 64'd0;
   logic        exp_halted = 1'b0;

   difftest_commit_monitor #(.CORE_ID(8'd0)) dut (
      .clock(clock), .reset_n(reset_n), .coreid(coreid),
      .c1_valid(c1_valid), .c2_valid(c2_valid), .c1_pc(c1_pc), .c2_pc(c2_pc),
      .c1_instr(c1_instr), .c2_instr(c2_instr), .c1_skip(c1_skip), .c2_skip(c2_skip),
      .c1_is_CNTinst(c1_is_CNTinst), .c2_is_CNTinst(c2_is_CNTinst),
      .c1_is_TLBFILL(c1_is_TLBFILL), .c2_is_TLBFILL(c2_is_TLBFILL),
      .c1_TLBFILL_index(c1_TLBFILL_index), .c2_TLBFILL_index(c2_TLBFILL_index),
      .c1_timer_64_value(c1_timer_64_value), .c2_timer_64_value(c2_timer_64_value),
      .c1_index(c1_index), .c2_index(c2_index), .c1_wen(c1_wen), .c2_wen(c2_wen),
      .c1_wdest(c1_wdest), .c2_wdest(c2_wdest), .c1_wdata(c1_wdata), .c2_wdata(c2_wdata),
      .gpr(gpr), .trap_valid(trap_valid), .trap_code(trap_code), .trap_pc(trap_pc),
      .trap_cycleCnt(trap_cycleCnt), .trap_instrCnt(trap_instrCnt),
      .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .mismatch(mismatch),
      .mismatch_idx(mismatch_idx), .mismatch_pc(mismatch_pc),
      .mismatch_expected(mismatch_expected), .mismatch_actual(mismatch_actual),
      .halted(halted), .trap_good(trap_good), .trap_code_o(trap_code_o),
      .trap_pc_o(trap_pc_o), .cnt_mismatch(cnt_mismatch)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_commits();
      c1_valid = 0; c2_valid = 0; c1_wen = 0; c2_wen = 0;
      c1_skip = 0; c2_skip = 0; c1_is_CNTinst = 0; c2_is_CNTinst = 0;
      c1_wdest = 0; c2_wdest = 0; c1_wdata = 0; c2_wdata = 0;
      c1_pc = 0; c2_pc = 0; trap_valid = 0; trap_code = 0; trap_pc = 0;
      trap_instrCnt = 0; trap_cycleCnt = 0;
   endtask

   task automatic set_gpr(input int r, input logic [31:0] v);
      gpr[r*32 +: 32] = v;
   endtask

   // One clock edge; outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clock);
      if (!reset_n) begin
         exp_cyc = 64'd0;
         exp_halted = 1'b0;
      end else if (!exp_halted) begin
         exp_cyc = exp_cyc + 64'd1;
      end
      #1;
   endtask

   task automatic commit1(input logic [4:0] d, input logic [31:0] v, input logic [31:0] pc);
      c1_valid = 1; c1_wen = 1; c1_wdest = d; c1_wdata = v; c1_pc = pc;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_cyc"}, cycle_cnt, 64'd0);
      check_eq({tag, "_instr"}, instr_cnt, 64'd0);
      check_eq({tag, "_mm"}, {63'd0, mismatch}, 64'd0);
      check_eq({tag, "_mm_info"}, {mismatch_idx, mismatch_pc, mismatch_expected, mismatch_actual}, 64'd0);
      check_eq({tag, "_halt"}, {62'd0, halted, trap_good}, 64'd0);
      check_eq({tag, "_trap"}, {23'd0, trap_code_o, trap_pc_o, cnt_mismatch}, 64'd0);
   endtask

   initial begin
      reset_n = 0; coreid = 0; gpr = '0;
      c1_instr = 32'h0000_0013; c2_instr = 32'h0000_0013;
      c1_is_TLBFILL = 0; c2_is_TLBFILL = 0; c1_TLBFILL_index = 0; c2_TLBFILL_index = 0;
      c1_timer_64_value = 0; c2_timer_64_value = 0; c1_index = 0; c2_index = 0;
      clear_commits();
      #1;
      step(); step();
      check_all_zero("reset");

      reset_n = 1;
      step(); step();
      check_eq("cyc_run", cycle_cnt, exp_cyc);

      // Single commit, matching register file.
      commit1(5'd5, 32'h1234, 32'h1C00_0000); set_gpr(5, 32'h1234);
      step(); clear_commits();
      check_eq("c1_instr", instr_cnt, 64'd1);
      check_eq("c1_mm", {63'd0, mismatch}, 64'd0);

      // Both slots hit reg 3; slot 2 is the younger value.
      commit1(5'd3, 32'h11, 32'h1C00_0004);
      c2_valid = 1; c2_wen = 1; c2_wdest = 3; c2_wdata = 32'h22; c2_pc = 32'h1C00_0008;
      set_gpr(3, 32'h22);
      step(); clear_commits();
      check_eq("dual_instr", instr_cnt, 64'd3);
      check_eq("dual_mm", {63'd0, mismatch}, 64'd0);

      // Skip adopts the core value.
      commit1(5'd4, 32'h0, 32'h1C00_000C); c1_skip = 1; set_gpr(4, 32'h99);
      step(); clear_commits();
      check_eq("skip_mm", {63'd0, mismatch}, 64'd0);
      c1_valid = 1; c1_pc = 32'h1C00_0010;
      step(); clear_commits();
      check_eq("nowrite_mm", {63'd0, mismatch}, 64'd0);
      check_eq("nowrite_instr", instr_cnt, 64'd5);

      // Counter read on slot 2 behaves like skip.
      c2_valid = 1; c2_wen = 1; c2_wdest = 6; c2_wdata = 32'h0; c2_is_CNTinst = 1;
      set_gpr(6, 32'h55);
      step(); clear_commits();
      check_eq("cnt_mm", {63'd0, mismatch}, 64'd0);
      check_eq("cnt_instr", instr_cnt, 64'd6);

      // Wrong core id: no count, no shadow write.
      coreid = 8'd1; commit1(5'd8, 32'h77, 32'h1C00_0020); c2_valid = 1;
      step(); clear_commits(); coreid = 8'd0;
      check_eq("wrongid_instr", instr_cnt, 64'd6);
      c1_valid = 1; c1_pc = 32'h1C00_0024;
      step(); clear_commits();
      check_eq("wrongid_shadow_mm", {63'd0, mismatch}, 64'd0);
      check_eq("wrongid_instr2", instr_cnt, 64'd7);

      // Mismatch on reg 7 from slot 2; reg 12 also differs but is higher.
      commit1(5'd9, 32'h5, 32'h1C00_000C); set_gpr(9, 32'h5);
      c2_valid = 1; c2_wen = 1; c2_wdest = 7; c2_wdata = 32'hA; c2_pc = 32'h1C00_0010;
      set_gpr(7, 32'hB); set_gpr(12, 32'h3);
      step(); clear_commits();
      check_eq("mm_flag", {63'd0, mismatch}, 64'd1);
      check_eq("mm_idx", {59'd0, mismatch_idx}, 64'd7);
      check_eq("mm_exp", {32'd0, mismatch_expected}, 64'hA);
      check_eq("mm_act", {32'd0, mismatch_actual}, 64'hB);
      check_eq("mm_pc", {32'd0, mismatch_pc}, 64'h1C00_0010);
      check_eq("mm_instr", instr_cnt, 64'd9);

      // Sticky: a later commit must not overwrite the first failure.
      commit1(5'd7, 32'hB, 32'h1C00_0014); set_gpr(12, 32'h0);
      step(); clear_commits();
      check_eq("sticky_flag", {63'd0, mismatch}, 64'd1);
      check_eq("sticky_pc", {32'd0, mismatch_pc}, 64'h1C00_0010);
      check_eq("sticky_exp", {32'd0, mismatch_expected}, 64'hA);
      check_eq("sticky_instr", instr_cnt, 64'd10);
      check_eq("sticky_cyc", cycle_cnt, exp_cyc);

      // Mid-run reset clears everything.
      reset_n = 0; gpr = '0;
      step();
      check_all_zero("midreset");
      reset_n = 1;

      // Commit plus good trap in the same cycle.
      commit1(5'd5, 32'h1234, 32'h1C00_0100); set_gpr(5, 32'h1234);
      trap_valid = 1; trap_code = 0; trap_pc = 32'h1C00_0100; trap_instrCnt = 64'd1;
      step(); clear_commits(); exp_halted = 1;
      check_eq("trap_halt", {63'd0, halted}, 64'd1);
      check_eq("trap_good", {63'd0, trap_good}, 64'd1);
      check_eq("trap_cntmm", {63'd0, cnt_mismatch}, 64'd0);
      check_eq("trap_pc", {32'd0, trap_pc_o}, 64'h1C00_0100);
      check_eq("trap_instr", instr_cnt, 64'd1);
      check_eq("trap_cyc", cycle_cnt, exp_cyc);

      // Frozen after halt, including a mismatching commit and another trap.
      commit1(5'd2, 32'h5, 32'h1C00_0104); set_gpr(2, 32'h6);
      c2_valid = 1; trap_valid = 1; trap_code = 8'h7;
      step(); step(); clear_commits();
      check_eq("frozen_instr", instr_cnt, 64'd1);
      check_eq("frozen_cyc", cycle_cnt, exp_cyc);
      check_eq("frozen_mm", {63'd0, mismatch}, 64'd0);
      check_eq("frozen_code", {56'd0, trap_code_o}, 64'd0);

      // Bad trap code with wrong instruction count.
      reset_n = 0; gpr = '0;
      step(); reset_n = 1;
      trap_valid = 1; trap_code = 8'h3; trap_pc = 32'h1C00_0200; trap_instrCnt = 64'd5;
      step(); clear_commits(); exp_halted = 1;
      check_eq("bad_halt", {63'd0, halted}, 64'd1);
      check_eq("bad_good", {63'd0, trap_good}, 64'd0);
      check_eq("bad_cntmm", {63'd0, cnt_mismatch}, 64'd1);
      check_eq("bad_code", {56'd0, trap_code_o}, 64'h3);
      check_eq("bad_cyc", cycle_cnt, exp_cyc);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
